// File: rtl/branch_comp_pkg.sv
// Shared constants for the RV32I branch condition evaluator.
// B-type funct3 encodings used by the execute stage.
package branch_comp_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/branch_comp_cmp_core.sv
// Operand comparator: equality, signed and unsigned less-than.
// Purely combinational; funct3 selection lives in the top level.
module branch_cmp_core #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            eq,
  output logic            lt_signed,
  output logic            lt_unsigned
);

  logic [XLEN:0] diff;

  // The extra top bit of the subtraction is the borrow.
  assign diff        = {1'b0, rs1} - {1'b0, rs2};
  assign lt_unsigned = diff[XLEN];
  assign eq          = (diff[XLEN-1:0] == '0);

  assign lt_signed = (rs1[XLEN-1] != rs2[XLEN-1])
                   ? rs1[XLEN-1]
                   : lt_unsigned;

endmodule

// File: rtl/branch_comp.sv
// Branch condition evaluator for the execute stage: combinational
// taken decision plus registered copy and saturating statistics.
module branch_comp
  import branch_comp_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [2:0]       branch_op,
  input  logic             branch_valid,
  output logic             branch_taken,
  output logic             branch_illegal,
  output logic             taken_q,
  output logic             valid_q,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic eq;
  logic lt_s;
  logic lt_u;

  branch_cmp_core #(
    .XLEN(XLEN)
  ) u_core (
    .rs1        (rs1_data),
    .rs2        (rs2_data),
    .eq         (eq),
    .lt_signed  (lt_s),
    .lt_unsigned(lt_u)
  );

  always_comb begin
    branch_taken   = 1'b0;
    branch_illegal = 1'b0;
    unique case (branch_op)
      F3_BEQ:  branch_taken = eq;
      F3_BNE:  branch_taken = ~eq;
      F3_BLT:  branch_taken = lt_s;
      F3_BGE:  branch_taken = ~lt_s;
      F3_BLTU: branch_taken = lt_u;
      F3_BGEU: branch_taken = ~lt_u;
      default: branch_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      valid_q <= branch_valid;
      taken_q <= branch_valid & branch_taken;
    end
  end

  // Counters stick at all-ones rather than wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_count <= '0;
      taken_count  <= '0;
    end else if (branch_valid) begin
      if (branch_count != CNT_MAX)
        branch_count <= branch_count + CNT_W'(1);
      if (branch_taken && taken_count != CNT_MAX)
        taken_count <= taken_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_comp.sv
// Self-checking bench for branch_comp: behavioural model plus
// hand-computed anchor cases, default and 4-bit counter variants.
module tb_branch_comp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [2:0]  op  = '0;
  logic        vld = 1'b0;

  logic        tk, ill, tq, vq;
  logic [31:0] bc, tc;
  logic        tk4, ill4, tq4, vq4;
  logic [3:0]  bc4, tc4;

  int n_chk  = 0;
  int n_fail = 0;
  bit started = 0;

  longint m_bc, m_tc, m_bc4, m_tc4;
  bit     m_vq, m_tq;

  always #5 clk = ~clk;

  branch_comp dut (
    .clk(clk), .rst(rst),
    .rs1_data(rs1), .rs2_data(rs2),
    .branch_op(op), .branch_valid(vld),
    .branch_taken(tk), .branch_illegal(ill),
    .taken_q(tq), .valid_q(vq),
    .branch_count(bc), .taken_count(tc)
  );

  branch_comp #(.XLEN(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .rs1_data(rs1), .rs2_data(rs2),
    .branch_op(op), .branch_valid(vld),
    .branch_taken(tk4), .branch_illegal(ill4),
    .taken_q(tq4), .valid_q(vq4),
    .branch_count(bc4), .taken_count(tc4)
  );

  function automatic bit ref_taken(
    input logic [31:0] a, input logic [31:0] b,
    input logic [2:0] f);
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = ua - (a[31] ? 64'sd4294967296 : 64'sd0);
    longint sb = ub - (b[31] ? 64'sd4294967296 : 64'sd0);
    case (f)
      3'd0: return ua == ub;
      3'd1: return ua != ub;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return ua < ub;
      3'd7: return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string nm,
                     input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic chkx(input string nm, input logic v,
                      input bit exp);
    n_chk++;
    if (v !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b @%0t",
               nm, v, exp, $time);
    end
  endtask

  // Model state follows the same edge the DUT samples.
  always @(posedge clk) begin
    if (rst) begin
      m_vq = 0; m_tq = 0;
      m_bc = 0; m_tc = 0; m_bc4 = 0; m_tc4 = 0;
    end else begin
      m_vq = vld;
      m_tq = vld && ref_taken(rs1, rs2, op);
      if (vld) begin
        m_bc  = (m_bc  < 64'd4294967295) ? m_bc + 1  : m_bc;
        m_bc4 = (m_bc4 < 64'd15)         ? m_bc4 + 1 : m_bc4;
        if (ref_taken(rs1, rs2, op)) begin
          m_tc  = (m_tc  < 64'd4294967295) ? m_tc + 1  : m_tc;
          m_tc4 = (m_tc4 < 64'd15)         ? m_tc4 + 1 : m_tc4;
        end
      end
    end
    started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      chkx("taken", tk, ref_taken(rs1, rs2, op));
      chkx("illegal", ill, op[2:1] == 2'b01);
      chkx("taken4", tk4, ref_taken(rs1, rs2, op));
      chkx("valid_q", vq, m_vq);
      chkx("taken_q", tq, m_tq);
      chkx("valid_q4", vq4, m_vq);
      chkx("taken_q4", tq4, m_tq);
      chk("branch_count", longint'(bc), m_bc);
      chk("taken_count", longint'(tc), m_tc);
      chk("branch_count4", longint'(bc4), m_bc4);
      chk("taken_count4", longint'(tc4), m_tc4);
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] f, input bit v,
                       input bit r);
    @(posedge clk);
    #2;
    rs1 = a; rs2 = b; op = f; vld = v; rst = r;
  endtask

  task automatic anchor(input string nm, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] f,
                        input bit exp_tk, input bit exp_ill);
    drive(a, b, f, 1'b0, 1'b0);
    #1;
    chkx({nm, "_taken"}, tk, exp_tk);
    chkx({nm, "_illegal"}, ill, exp_ill);
  endtask

  initial begin
    logic [31:0] a, b;
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    #1;
    chk("reset_bc", longint'(bc), 0);
    chk("reset_tc", longint'(tc), 0);
    chkx("reset_vq", vq, 1'b0);
    chkx("reset_tq", tq, 1'b0);

    anchor("beq_eq", 10, 10, 3'b000, 1, 0);
    anchor("bne_eq", 10, 10, 3'b001, 0, 0);
    anchor("blt_5_10", 5, 10, 3'b100, 1, 0);
    anchor("bge_5_10", 5, 10, 3'b101, 0, 0);
    anchor("bltu_m1_1", 32'hFFFF_FFFF, 1, 3'b110, 0, 0);
    anchor("bgeu_m1_1", 32'hFFFF_FFFF, 1, 3'b111, 1, 0);
    anchor("blt_m1_1", 32'hFFFF_FFFF, 1, 3'b100, 1, 0);
    anchor("bge_m1_1", 32'hFFFF_FFFF, 1, 3'b101, 0, 0);
    anchor("op010", 7, 7, 3'b010, 0, 1);
    anchor("op011", 3, 9, 3'b011, 0, 1);

    // Four valid branches, three taken.
    drive(0, 0, 0, 0, 1);
    drive(10, 10, 3'b000, 1, 0);
    drive(5, 10, 3'b100, 1, 0);
    drive(5, 10, 3'b101, 1, 0);
    #1 chkx("seq_tq_b1", tq, 1'b1);
    drive(32'hFFFF_FFFF, 1, 3'b111, 1, 0);
    #1 chkx("seq_tq_b3", tq, 1'b0);
    drive(0, 0, 0, 0, 0);
    #1;
    chkx("seq_tq_b4", tq, 1'b1);
    chk("seq_bc", longint'(bc), 4);
    chk("seq_tc", longint'(tc), 3);

    // Reset wins over a simultaneous valid taken branch.
    drive(1, 1, 3'b000, 1, 1);
    drive(0, 0, 0, 0, 0);
    #1;
    chk("rstv_bc", longint'(bc), 0);
    chk("rstv_tc", longint'(tc), 0);
    chkx("rstv_vq", vq, 1'b0);
    chkx("rstv_tq", tq, 1'b0);

    // Saturation of the 4-bit counters.
    for (int i = 0; i < 17; i++)
      drive(42, 42, 3'b000, 1, 0);
    drive(0, 0, 0, 0, 0);
    #1;
    chk("sat_bc4", longint'(bc4), 15);
    chk("sat_tc4", longint'(tc4), 15);
    chk("sat_bc", longint'(bc), 17);
    chk("sat_tc", longint'(tc), 17);

    for (int i = 0; i < 600; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = a;
        1: a = 32'h8000_0000;
        2: b = 32'hFFFF_FFFF;
        3: begin a[31] = b[31]; end
        default: ;
      endcase
      drive(a, b, 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 3) != 0),
            $urandom_range(0, 49) == 0);
    end
    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_comp.md
# branch_comp

Branch condition evaluator for the RV32I execute stage. It compares two register operands under a RISC-V B-type funct3 code and produces a zero-latency combinational branch-taken decision for the next-PC mux. It also provides a one-cycle registered copy of the decision and saturating branch statistics counters for the performance/debug path.

## Interface
Parameters:
- XLEN, 32, operand width in bits.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  system clock; all sequential state on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rs1_data  in  XLEN  first operand (rs1).
- rs2_data  in  XLEN  second operand (rs2).
- branch_op  in  3  funct3 of the branch instruction.
- branch_valid  in  1  a branch instruction is in execute this cycle; gates the registered and counter paths only.
- branch_taken  out  1  combinational taken decision.
- branch_illegal  out  1  combinational; high when branch_op is 010 or 011.
- taken_q  out  1  registered branch_taken, qualified by branch_valid.
- valid_q  out  1  registered branch_valid.
- branch_count  out  CNT_W  number of valid branches evaluated.
- taken_count  out  CNT_W  number of valid branches taken.

## Operation
- Decode of branch_op:
  - 000 BEQ: taken when rs1 == rs2.
  - 001 BNE: taken when rs1 != rs2.
  - 100 BLT: taken when rs1 < rs2, two's-complement signed.
  - 101 BGE: taken when rs1 >= rs2, signed.
  - 110 BLTU: taken when rs1 < rs2, unsigned.
  - 111 BGEU: taken when rs1 >= rs2, unsigned.
  - 010, 011: branch_taken = 0 and branch_illegal = 1.
- Comparison semantics:
  - Full XLEN-bit compare, no sign extension.
  - Signed compare uses the MSB as the sign bit. Example: 0xFFFFFFFF is -1 for BLT/BGE and 4294967295 for BLTU/BGEU.
- branch_taken and branch_illegal:
  - Pure functions of rs1_data, rs2_data and branch_op.
  - Independent of clk, rst and branch_valid, and valid even while rst is asserted.
- Registered path, each rising edge:
  - valid_q <= branch_valid.
  - taken_q <= branch_valid & branch_taken.
- Counters, on an edge with branch_valid = 1:
  - branch_count increments by 1.
  - taken_count increments when branch_taken = 1.
  - An illegal op counts as evaluated and not taken.
  - Both counters saturate at all-ones and never wrap.

## Timing
- Combinational outputs: zero-cycle latency, no internal state.
- taken_q and valid_q: exactly one cycle after the sampled inputs.
- Counters: new value visible the cycle after the valid input.
- Reset values:
  - taken_q = 0, valid_q = 0.
  - branch_count = 0, taken_count = 0.
- Reset has priority over a simultaneous valid branch: the counters clear and do not increment that cycle.
- Counters at saturation with a new valid branch: they hold at all-ones.

## Structure
- Shared package holds the funct3 constants: F3_BEQ=000, F3_BNE=001, F3_BLT=100, F3_BGE=101, F3_BLTU=110, F3_BGEU=111.
- Natural sub-module: branch_cmp_core.
  - Purely combinational.
  - Computes eq, lt_signed and lt_unsigned from the operands.
  - The top level does the funct3 select, registers and counters.
- Derived relations:
  - lt_unsigned comes from an XLEN+1-bit subtraction borrow.
  - lt_signed = (rs1[MSB] != rs2[MSB]) ? rs1[MSB] : lt_unsigned.

## Test plan
- rs1=10, rs2=10, op=000 -> taken=1. Same operands, op=001 -> taken=0.
- rs1=5, rs2=10: op=100 -> taken=1; op=101 -> taken=0.
- rs1=0xFFFFFFFF, rs2=1:
  - op=110 -> taken=0; op=111 -> taken=1.
  - op=100 -> taken=1; op=101 -> taken=0.
- op=010 and op=011 with any operands -> taken=0, illegal=1.
- Reset, then 4 valid branches of which 3 are taken:
  - branch_count=4, taken_count=3.
  - taken_q follows each branch one cycle later.
  - rst asserted together with a valid branch -> all counters and registered outputs are 0 on the next cycle.
- With CNT_W=4, drive 17 valid taken branches -> both counters hold at 15.
